// File: rtl/memory_bus_arbiter.sv
// Round-robin arbiter sharing one memory-bus slave port among MASTERS requesters,
// with ID-routed responses. Define MEMORY_ARBITER_STATS_EN to build per-master grant counters.
module memory_bus_arbiter #(
  parameter int MASTERS       = 4,
  parameter int DATA_WIDTH    = 24,
  parameter int ADDRESS_WIDTH = 32,
  parameter int ID_WIDTH      = 4
) (
  input  logic                                     clock,
  input  logic                                     reset,
  input  logic [MASTERS-1:0]                       mValid,
  output logic [MASTERS-1:0]                       mTaken,
  input  logic [MASTERS-1:0][ADDRESS_WIDTH-1:0]    mAddress,
  input  logic [MASTERS-1:0][DATA_WIDTH-1:0]       mData,
  input  logic [MASTERS-1:0]                       mWrite,
  output logic [MASTERS-1:0]                       rValid,
  input  logic [MASTERS-1:0]                       rTaken,
  output logic [DATA_WIDTH-1:0]                    rData,
  output logic                                     sValid,
  output logic [ADDRESS_WIDTH-1:0]                 sAddress,
  output logic [DATA_WIDTH-1:0]                    sData,
  output logic                                     sWrite,
  output logic [ID_WIDTH-1:0]                      sID,
  input  logic                                     sTaken,
  input  logic                                     respValid,
  input  logic [ID_WIDTH-1:0]                      respID,
  input  logic [DATA_WIDTH-1:0]                    respData,
  output logic                                     respTaken,
  output logic [7:0]                               dropCount,
  output logic [MASTERS-1:0][15:0]                 grantCount
);

  localparam int PTR_W = (MASTERS > 1) ? $clog2(MASTERS) : 1;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t             state;
  logic [PTR_W-1:0]   pointer;
  logic [PTR_W-1:0]   granted;
  logic [PTR_W-1:0]   winner;
  logic [PTR_W-1:0]   cand;
  logic               any_valid;
  logic               resp_in_range;

  // Scan from the highest offset down so the lowest offset from pointer wins.
  always_comb begin
    any_valid = 1'b0;
    winner    = '0;
    cand      = '0;
    for (int k = MASTERS - 1; k >= 0; k--) begin
      cand = PTR_W'((int'(pointer) + k) % MASTERS);
      if (mValid[cand]) begin
        any_valid = 1'b1;
        winner    = cand;
      end
    end
  end

  // Grants never look at sTaken, so there is no loop through the slave.
  always_comb begin
    mTaken = '0;
    if (state == IDLE && any_valid) begin
      mTaken[winner] = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      pointer  <= '0;
      granted  <= '0;
      sValid   <= 1'b0;
      sAddress <= '0;
      sData    <= '0;
      sWrite   <= 1'b0;
      sID      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            state    <= HOLD;
            granted  <= winner;
            sValid   <= 1'b1;
            sAddress <= mAddress[winner];
            sData    <= mData[winner];
            sWrite   <= mWrite[winner];
            sID      <= ID_WIDTH'(winner);
          end
        end
        HOLD: begin
          if (sTaken) begin
            state   <= IDLE;
            sValid  <= 1'b0;
            pointer <= (granted == PTR_W'(MASTERS - 1)) ? '0 : granted + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign resp_in_range = ({1'b0, respID} < (ID_WIDTH + 1)'(MASTERS));
  assign rData         = respData;

  // Responses with an unknown ID are swallowed so the slave never stalls on them.
  always_comb begin
    rValid    = '0;
    respTaken = 1'b1;
    if (resp_in_range) begin
      rValid[respID[PTR_W-1:0]] = respValid;
      respTaken                 = rTaken[respID[PTR_W-1:0]];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dropCount <= '0;
    end else if (respValid && !resp_in_range && dropCount != 8'hFF) begin
      dropCount <= dropCount + 8'd1;
    end
  end

`ifdef MEMORY_ARBITER_STATS_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      grantCount <= '0;
    end else begin
      for (int i = 0; i < MASTERS; i++) begin
        if (mTaken[i]) begin
          grantCount[i] <= grantCount[i] + 16'd1;
        end
      end
    end
  end
`else
  assign grantCount = '0;
`endif

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Scoreboard bench for memory_bus_arbiter: a transaction-level model predicts grants,
// slave requests and routed responses; a monitor pops and compares what the DUT presents.
module tb_memory_bus_arbiter;

  localparam int M = 4;

  typedef struct {
    logic [31:0] addr;
    logic [23:0] data;
    logic        wr;
    logic [3:0]  id;
  } req_t;

  typedef struct {
    int          id;
    logic [23:0] data;
  } resp_t;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [M-1:0]      mValid = '0;
  logic [M-1:0]      mTaken;
  logic [M-1:0][31:0] mAddress = '0;
  logic [M-1:0][23:0] mData = '0;
  logic [M-1:0]      mWrite = '0;
  logic [M-1:0]      rValid;
  logic [M-1:0]      rTaken = '0;
  logic [23:0]       rData;
  logic              sValid;
  logic [31:0]       sAddress;
  logic [23:0]       sData;
  logic              sWrite;
  logic [3:0]        sID;
  logic              sTaken = 1'b0;
  logic              respValid = 1'b0;
  logic [3:0]        respID = '0;
  logic [23:0]       respData = '0;
  logic              respTaken;
  logic [7:0]        dropCount;
  logic [M-1:0][15:0] grantCount;

  memory_bus_arbiter #(.MASTERS(M), .DATA_WIDTH(24), .ADDRESS_WIDTH(32), .ID_WIDTH(4)) dut (
    .clock(clock), .reset(reset),
    .mValid(mValid), .mTaken(mTaken), .mAddress(mAddress), .mData(mData), .mWrite(mWrite),
    .rValid(rValid), .rTaken(rTaken), .rData(rData),
    .sValid(sValid), .sAddress(sAddress), .sData(sData), .sWrite(sWrite), .sID(sID),
    .sTaken(sTaken),
    .respValid(respValid), .respID(respID), .respData(respData), .respTaken(respTaken),
    .dropCount(dropCount), .grantCount(grantCount)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int errors  = 0;

  // Reference model: is the bus busy, who owns it, where the next search starts.
  bit          m_busy;
  int          m_ptr;
  int          m_win;
  int          m_drop;
  logic [15:0] m_grants [M];
  req_t        exp_req [$];
  resp_t       exp_resp [$];
  logic [M-1:0] exp_tk;
  int          g_win;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0;
    m_ptr  = 0;
    m_win  = 0;
    m_drop = 0;
    for (int i = 0; i < M; i++) m_grants[i] = '0;
    exp_req.delete();
    exp_resp.delete();
  endtask

  task automatic check_comb();
    logic [M-1:0] exp_rv;
    logic         exp_rt;
    int           idx;
    req_t         r;
    chk("sValid", 64'(sValid), 64'(m_busy));
    if (m_busy && exp_req.size() > 0) begin
      chk("sAddress_hold", 64'(sAddress), 64'(exp_req[0].addr));
      chk("sID_hold", 64'(sID), 64'(exp_req[0].id));
    end
    exp_tk = '0;
    g_win  = -1;
    if (!m_busy) begin
      for (int k = 0; k < M; k++) begin
        idx = (m_ptr + k) % M;
        if (g_win < 0 && mValid[idx]) g_win = idx;
      end
    end
    if (g_win >= 0) begin
      exp_tk[g_win] = 1'b1;
      r.addr = mAddress[g_win];
      r.data = mData[g_win];
      r.wr   = mWrite[g_win];
      r.id   = 4'(g_win);
      exp_req.push_back(r);
    end
    chk("mTaken", 64'(mTaken), 64'(exp_tk));
    exp_rv = '0;
    exp_rt = 1'b1;
    if (int'(respID) < M) begin
      exp_rv[respID] = respValid;
      exp_rt         = rTaken[respID];
      if (respValid && rTaken[respID]) exp_resp.push_back('{int'(respID), respData});
    end
    chk("rValid", 64'(rValid), 64'(exp_rv));
    chk("respTaken", 64'(respTaken), 64'(exp_rt));
    chk("dropCount", 64'(dropCount), 64'(m_drop));
    for (int i = 0; i < M; i++) begin
`ifdef MEMORY_ARBITER_STATS_EN
      chk("grantCount", 64'(grantCount[i]), 64'(m_grants[i]));
`else
      chk("grantCount", 64'(grantCount[i]), 64'd0);
`endif
    end
  endtask

  task automatic model_update();
    if (!m_busy && g_win >= 0) begin
      m_busy = 1;
      m_win  = g_win;
      m_grants[g_win] = m_grants[g_win] + 16'd1;
    end else if (m_busy && sTaken) begin
      m_busy = 0;
      m_ptr  = (m_win + 1) % M;
    end
    if (respValid && int'(respID) >= M && m_drop < 255) m_drop++;
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic step();
    #2;
    check_comb();
    @(posedge clock);
    model_update();
    @(negedge clock);
  endtask

  // Monitor: pops expectations whenever the DUT completes a request or a response.
  initial begin
    req_t  r;
    resp_t p;
    forever begin
      @(negedge clock);
      #3;
      if (reset && sValid && sTaken) begin
        if (exp_req.size() == 0) begin
          vectors++; errors++;
          $display("FAIL slave_req: got id %0d expected no request", sID);
        end else begin
          r = exp_req.pop_front();
          chk("slave_addr", 64'(sAddress), 64'(r.addr));
          chk("slave_data", 64'(sData), 64'(r.data));
          chk("slave_write", 64'(sWrite), 64'(r.wr));
          chk("slave_id", 64'(sID), 64'(r.id));
        end
      end
      for (int i = 0; i < M; i++) begin
        if (reset && rValid[i] && rTaken[i]) begin
          if (exp_resp.size() == 0) begin
            vectors++; errors++;
            $display("FAIL resp: got master %0d expected no response", i);
          end else begin
            p = exp_resp.pop_front();
            chk("resp_master", 64'(i), 64'(p.id));
            chk("resp_data", 64'(rData), 64'(p.data));
          end
        end
      end
    end
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    chk("reset_sAddress", 64'(sAddress), 64'd0);
    chk("reset_sID", 64'(sID), 64'd0);
    chk("reset_sWrite", 64'(sWrite), 64'd0);

    // Single request from master 2
    mValid = 4'b0100; mAddress[2] = 32'h100; mData[2] = 24'hABCDEF; mWrite[2] = 1'b1; sTaken = 1'b1;
    step();
    mValid = '0;
    step();
    step();

    // Round robin with everyone valid
    for (int i = 0; i < M; i++) begin
      mAddress[i] = 32'h1000 * (i + 1); mData[i] = 24'(i + 16); mWrite[i] = i[0];
    end
    mValid = 4'b1111; sTaken = 1'b1;
    repeat (10) step();

    // Backpressure on master 1
    mValid = 4'b0010; mAddress[1] = 32'hCAFE0; sTaken = 1'b0;
    step();
    mValid = 4'b1111;
    repeat (5) step();
    sTaken = 1'b1;
    step();
    mValid = '0;
    step();

    // Response routing to master 3 with delayed acceptance
    respValid = 1'b1; respID = 4'd3; respData = 24'h123456; rTaken = '0;
    repeat (2) step();
    rTaken = 4'b1000;
    step();
    respValid = 1'b0; rTaken = '0;
    step();

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      mValid = 4'($urandom_range(0, 15));
      for (int i = 0; i < M; i++) begin
        mAddress[i] = $urandom(); mData[i] = 24'($urandom()); mWrite[i] = 1'($urandom());
      end
      sTaken    = ($urandom_range(0, 2) != 0);
      respValid = 1'($urandom());
      respID    = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
      respData  = 24'($urandom());
      rTaken    = 4'($urandom_range(0, 15));
      step();
    end
    respValid = 1'b0; mValid = '0; sTaken = 1'b1;
    repeat (2) step();

    // Out-of-range IDs until the drop counter saturates
    respValid = 1'b1; respID = 4'd9; rTaken = 4'b1111;
    repeat (300) step();
    respValid = 1'b0; rTaken = '0;
    step();

    // Move the pointer away from 0, then reset during HOLD
    mValid = 4'b0100; sTaken = 1'b1;
    step();
    mValid = '0;
    step();
    mValid = 4'b0010; sTaken = 1'b0;
    step();
    mValid = '0;
    step();
    #1 reset = 1'b0;
    #1;
    chk("reset_hold_sValid", 64'(sValid), 64'd0);
    chk("reset_hold_grantCount", 64'(grantCount), 64'd0);
    chk("reset_hold_dropCount", 64'(dropCount), 64'd0);
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    mValid = 4'b1111; sTaken = 1'b1;
    repeat (6) step();

    // Responses still routed after reset
    respValid = 1'b1; respID = 4'd1; respData = 24'h0F0F0F; rTaken = 4'b0010;
    step();
    respValid = 1'b0; rTaken = '0; mValid = '0;
    repeat (3) step();
    chk("req_queue_empty", 64'(exp_req.size()), 64'd0);
    chk("resp_queue_empty", 64'(exp_resp.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/memory_bus_arbiter.md
# memory_bus_arbiter

- Shares one memory-bus slave port between `MASTERS` requesters such as ray-memory units and the pixel writer.
- Uses round-robin arbitration with a registered request stage.
- Routes each slave response back to its requester by master ID.
- Sits between the traversal/pixel engines and the memory controller.

## Interface
Parameters:
- `MASTERS`, 4: number of requesters; index i owns bus ID i.
- `DATA_WIDTH`, 24: bus data width.
- `ADDRESS_WIDTH`, 32: bus address width.
- `ID_WIDTH`, 4: ID width; must satisfy 2^ID_WIDTH ≥ MASTERS.

Ports:
- `clock`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `mValid`  in  [MASTERS]  request valid per master.
- `mTaken`  out  [MASTERS]  request accepted this cycle (combinational).
- `mAddress`  in  [MASTERS][ADDRESS_WIDTH]  request address.
- `mData`  in  [MASTERS][DATA_WIDTH]  write data.
- `mWrite`  in  [MASTERS]  1 = write, 0 = read.
- `rValid`  out  [MASTERS]  response valid to master.
- `rTaken`  in  [MASTERS]  master accepts response.
- `rData`  out  [DATA_WIDTH]  response data, shared by all masters.
- `sValid`, `sAddress`, `sData`, `sWrite`, `sID`  out  1/ADDRESS_WIDTH/DATA_WIDTH/1/ID_WIDTH  registered request to slave.
- `sTaken`  in  1  slave accepts request.
- `respValid`, `respID`, `respData`  in  1/ID_WIDTH/DATA_WIDTH  slave response.
- `respTaken`  out  1  response consumed.
- `dropCount`  out  8  responses discarded for an out-of-range ID; saturating.
- `grantCount`  out  [MASTERS][16]  accepted requests per master (see Configuration).

## Operation
- States: IDLE and HOLD. Reset: state IDLE, pointer 0, `sValid` 0, `sAddress`/`sData`/`sWrite`/`sID` 0, `dropCount` 0, `grantCount` 0.
- IDLE:
  - Winner = first i with `mValid[i]` searching from `pointer` upward, wrapping MASTERS-1 → 0.
  - Assert `mTaken[winner]` only; all other `mTaken` bits are 0.
  - Latch address, data and write into the s* registers; `sID` ← winner.
  - Next state HOLD. If no master is valid, stay IDLE.
- HOLD:
  - `sValid` = 1; the s* registers are stable.
  - All `mTaken` = 0.
  - On `sTaken`: go to IDLE, pointer ← (winner+1) mod MASTERS.
- Response path (combinational, any state):
  - `rValid[respID]` = `respValid` when respID < MASTERS; `rData` = `respData`.
  - `respTaken` = `rTaken[respID]`.
  - If respID ≥ MASTERS: `respTaken` = 1, no `rValid` asserted, `dropCount` += 1, saturating at 255.
- Request and response paths are independent. A response may complete in the same cycle as a grant or an `sTaken`.
- `mTaken` depends only on state, pointer and `mValid`; it never depends on `sTaken`, so there is no combinational loop.

## Timing
- Request accepted in cycle N → `sValid` high from cycle N+1 until the cycle `sTaken` is sampled high, inclusive.
- Minimum spacing between slave requests is 2 cycles, because IDLE and HOLD alternate; there is no bypass.
- Response path latency is 0 cycles.
- Fairness: with all masters continuously valid, grants rotate 0,1,2,3,0,…; no master waits more than MASTERS grants.
- A master that drops `mValid` before being granted loses nothing; the arbiter holds no per-master state.
- Reset asserted mid-HOLD: `sValid` drops asynchronously and the in-flight request is abandoned. Responses arriving after reset are still routed by ID.

## Configuration
- `MEMORY_ARBITER_STATS_EN` defined:
  - `grantCount[i]` increments on each `mTaken[i]` and wraps at 2^16.
  - Counters clear on reset only.
- Not defined: `grantCount` is tied to 0 and no counter flops are built. `dropCount` is always present.

## Test plan
- Single request: `mValid[2]`=1, addr 0x100, write, data 0xABCDEF, `sTaken`=1 → `mTaken[2]` in cycle 0; cycle 1 shows `sValid`=1, `sAddress`=0x100, `sID`=2, `sWrite`=1; IDLE in cycle 2.
- Round robin: all four masters valid, `sTaken` always 1 → grant order 0,1,2,3,0 on cycles 0,2,4,6,8.
- Backpressure: `sTaken`=0 for 5 cycles after a grant to master 1 → `sValid` and `sAddress` stable for 5 cycles; no new `mTaken` until cycle 7.
- Response routing: `respValid`=1, `respID`=3, `respData`=0x123456, `rTaken[3]`=0 for 2 cycles then 1 → `rValid[3]` high for all 3 cycles, `respTaken` high only in the third.
- Bad ID: `respID`=9 with MASTERS=4 for 300 responses → `respTaken`=1 each cycle, no `rValid` asserted, `dropCount`=255.
- Reset in HOLD: assert `reset` low mid-hold → `sValid` 0 immediately, pointer 0. With the stats macro, `grantCount` reads 0.
